// File: rtl/idx_to_vec_acc_pkg.sv
// ============================================================================
//  Module   : idx_to_vec_acc_pkg
//  Purpose  : Shared FSM state type and width helpers for the index-to-bitmap
//             accumulator. Optional feature macro: IDX_TO_VEC_ACC_DUP_DETECT_EN
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package idx_to_vec_acc_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    // Index width for a W-bit vector; clamped so a degenerate W never yields 0.
    function automatic int unsigned idx_w(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    // Count width able to hold the value W itself.
    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage : idx_to_vec_acc_pkg

`default_nettype wire

// File: rtl/idx_to_vec_acc_if.sv
// ============================================================================
//  Module   : idx_to_vec_acc_if
//  Purpose  : Index-beat input and bitmap output handshakes of the accumulator.
//             Optional feature macro: IDX_TO_VEC_ACC_DUP_DETECT_EN (out_dup)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface idx_to_vec_acc_if
    import idx_to_vec_acc_pkg::*;
#(
    parameter int unsigned W = 32
);

    localparam int unsigned IW = idx_w(W);
    localparam int unsigned CW = cnt_w(W);

    logic          in_vld;
    logic [IW-1:0] in_idx;
    logic          in_last;
    logic          in_rdy;
    logic          out_vld;
    logic [W-1:0]  out_vec;
    logic [CW-1:0] out_cnt;
    logic          out_rdy;
`ifdef IDX_TO_VEC_ACC_DUP_DETECT_EN
    logic          out_dup;
`endif

    // Master: the producer of index beats and consumer of frames.
    modport master (
        output in_vld,
        output in_idx,
        output in_last,
        input  in_rdy,
        input  out_vld,
        input  out_vec,
        input  out_cnt,
`ifdef IDX_TO_VEC_ACC_DUP_DETECT_EN
        input  out_dup,
`endif
        output out_rdy
    );

    modport slave (
        input  in_vld,
        input  in_idx,
        input  in_last,
        output in_rdy,
        output out_vld,
        output out_vec,
        output out_cnt,
`ifdef IDX_TO_VEC_ACC_DUP_DETECT_EN
        output out_dup,
`endif
        input  out_rdy
    );

endinterface : idx_to_vec_acc_if

`default_nettype wire

// File: rtl/idx_to_vec_acc_dec_onehot.sv
// ============================================================================
//  Module   : dec_onehot
//  Purpose  : Combinational index-to-one-hot decoder with an in-range flag.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_onehot
    import idx_to_vec_acc_pkg::*;
#(
    parameter  int unsigned W  = 32,
    localparam int unsigned IW = idx_w(W)
) (
    input  wire logic [IW-1:0] idx_i,
    output      logic [W-1:0]  onehot_o,
    output      logic          in_range_o
);

    // W always fits in IW+1 bits, so the compare never truncates.
    localparam logic [IW:0] c_W = (IW+1)'(W);

    assign in_range_o = ({1'b0, idx_i} < c_W);

    for (genvar b = 0; b < int'(W); b++) begin : g_bit
        assign onehot_o[b] = (idx_i == IW'(b));
    end

endmodule : dec_onehot

`default_nettype wire

// File: rtl/idx_to_vec_acc.sv
// ============================================================================
//  Module   : idx_to_vec_acc
//  Purpose  : Accumulates a stream of bit indices into a W-bit bitmap per frame
//             and emits it with its population count.
//             Optional feature macro: IDX_TO_VEC_ACC_DUP_DETECT_EN
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module idx_to_vec_acc
    import idx_to_vec_acc_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input wire logic      clk,
    input wire logic      rst,
    idx_to_vec_acc_if.slave bus
);

    localparam int unsigned IW = idx_w(W);
    localparam int unsigned CW = cnt_w(W);

    typedef logic [IW-1:0] idx_t;
    typedef logic [CW-1:0] cnt_t;

    state_t       state_q, state_d;
    logic [W-1:0] acc_q, acc_d;
    cnt_t         cnt_q, cnt_d;

    idx_t         w_idx;
    logic [W-1:0] w_onehot;
    logic         w_in_range;
    logic         w_in_rdy;
    logic         w_beat;
    logic         w_release;
    logic [W-1:0] w_base_acc;
    cnt_t         w_base_cnt;
    logic         w_hit;

    assign w_idx = bus.in_idx;

    dec_onehot #(
        .W (W)
    ) u_dec (
        .idx_i      (w_idx),
        .onehot_o   (w_onehot),
        .in_range_o (w_in_range)
    );

    // out_rdy feeds in_rdy combinationally so frames can run back to back.
    assign w_in_rdy  = (state_q == ACCUM) | bus.out_rdy;
    assign w_beat    = bus.in_vld & w_in_rdy;
    assign w_release = (state_q == EMIT) & bus.out_rdy;

    // On release the accepted beat starts a new frame from an empty bitmap.
    assign w_base_acc = w_release ? '0 : acc_q;
    assign w_base_cnt = w_release ? '0 : cnt_q;
    assign w_hit      = |(w_base_acc & w_onehot);

    always_comb begin
        state_d = state_q;
        acc_d   = w_base_acc;
        cnt_d   = w_base_cnt;

        if (w_beat && w_in_range && !w_hit) begin
            acc_d = w_base_acc | w_onehot;
            cnt_d = w_base_cnt + cnt_t'(1);
        end

        case (state_q)
            ACCUM: begin
                if (w_beat && bus.in_last) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (w_release) begin
                    state_d = (w_beat && bus.in_last) ? EMIT : ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef IDX_TO_VEC_ACC_DUP_DETECT_EN
    logic dup_q, dup_d;

    // Sticky per frame; a fresh frame can only be seeded by an out-of-range beat.
    always_comb begin
        dup_d = w_release ? 1'b0 : dup_q;
        if (w_beat && (!w_in_range || w_hit)) begin
            dup_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dup_q <= 1'b0;
        end else begin
            dup_q <= dup_d;
        end
    end

    assign bus.out_dup = dup_q;
`endif

    assign bus.in_rdy  = w_in_rdy;
    assign bus.out_vld = (state_q == EMIT);
    assign bus.out_vec = acc_q;
    assign bus.out_cnt = cnt_q;

endmodule : idx_to_vec_acc

`default_nettype wire

// File: tb/tb_idx_to_vec_acc.sv
// ============================================================================
//  Module   : tb_idx_to_vec_acc
//  Purpose  : Self-checking bench for idx_to_vec_acc at W=32 and W=20.
//             Optional feature macro: IDX_TO_VEC_ACC_DUP_DETECT_EN
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idx_to_vec_acc;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    idx_to_vec_acc_if #(.W(32)) if32 ();
    idx_to_vec_acc_if #(.W(20)) if20 ();

    idx_to_vec_acc #(.W(32)) u32 (.clk(clk), .rst(rst), .bus(if32));
    idx_to_vec_acc #(.W(20)) u20 (.clk(clk), .rst(rst), .bus(if20));

    int checks = 0;
    int errors = 0;

    // Reference model: beats of the open frame, and the frame awaiting release.
    int          cur_q[$];
    logic        pend_v   = 1'b0;
    logic [31:0] pend_vec = '0;
    int          pend_cnt = 0;
    logic        pend_dup = 1'b0;

    logic        o_vld, o_rdy, o_dup;
    logic [31:0] o_vec;
    int          o_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int sel);
        if (sel == 0) begin
            o_vld = if32.out_vld;
            o_rdy = if32.in_rdy;
            o_vec = if32.out_vec;
            o_cnt = int'(if32.out_cnt);
`ifdef IDX_TO_VEC_ACC_DUP_DETECT_EN
            o_dup = if32.out_dup;
`else
            o_dup = 1'b0;
`endif
        end else begin
            o_vld = if20.out_vld;
            o_rdy = if20.in_rdy;
            o_vec = 32'(if20.out_vec);
            o_cnt = int'(if20.out_cnt);
`ifdef IDX_TO_VEC_ACC_DUP_DETECT_EN
            o_dup = if20.out_dup;
`else
            o_dup = 1'b0;
`endif
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [4:0] idx,
                         input logic last, input logic ordy);
        if32.in_vld = 1'b0; if32.in_idx = '0; if32.in_last = 1'b0; if32.out_rdy = 1'b1;
        if20.in_vld = 1'b0; if20.in_idx = '0; if20.in_last = 1'b0; if20.out_rdy = 1'b1;
        if (sel == 0) begin
            if32.in_vld = v; if32.in_idx = idx; if32.in_last = last; if32.out_rdy = ordy;
        end else begin
            if20.in_vld = v; if20.in_idx = idx; if20.in_last = last; if20.out_rdy = ordy;
        end
    endtask

    // Bitmap built from the frame's index list as a set of integers.
    task automatic close_frame(input int w);
        logic [31:0] v;
        logic        d;
        v = '0;
        d = 1'b0;
        foreach (cur_q[i]) begin
            if (cur_q[i] >= w)  d = 1'b1;
            else if (v[cur_q[i]]) d = 1'b1;
            else v[cur_q[i]] = 1'b1;
        end
        pend_vec = v;
        pend_cnt = $countones(v);
        pend_dup = d;
        pend_v   = 1'b1;
        cur_q.delete();
    endtask

    task automatic cyc(input int sel, input logic v, input logic [4:0] idx,
                       input logic last, input logic ordy, output logic took);
        int   w;
        logic exp_rdy;
        w = (sel == 0) ? 32 : 20;
        drive(sel, v, idx, last, ordy);
        #1;
        sample(sel);
        exp_rdy = !pend_v | ordy;
        chk($sformatf("in_rdy_w%0d", w), 32'(o_rdy), 32'(exp_rdy));
        chk($sformatf("out_vld_w%0d", w), 32'(o_vld), 32'(pend_v));
        if (pend_v) begin
            chk($sformatf("out_vec_w%0d", w), o_vec, pend_vec);
            chk($sformatf("out_cnt_w%0d", w), 32'(o_cnt), 32'(pend_cnt));
`ifdef IDX_TO_VEC_ACC_DUP_DETECT_EN
            chk($sformatf("out_dup_w%0d", w), 32'(o_dup), 32'(pend_dup));
`endif
        end
        took = v & exp_rdy;
        if (pend_v && ordy) pend_v = 1'b0;
        if (took) begin
            cur_q.push_back(int'(idx));
            if (last) close_frame(w);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 1'b0, 5'd0, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur_q.delete();
        pend_v = 1'b0;
    endtask

    task automatic run_random(input int sel, input int cycles);
        logic       hv, rl, ro, took, done;
        logic [4:0] ri;
        hv = 1'b0; rl = 1'b0; ri = '0;
        for (int n = 0; n < cycles; n++) begin
            if (!hv) begin
                hv = ($urandom_range(0, 9) < 7);
                ri = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7))
                                                 : 5'($urandom_range(0, 31));
                rl = ($urandom_range(0, 3) == 0);
            end
            ro = ($urandom_range(0, 9) < 6);
            cyc(sel, hv, ri, rl, ro, took);
            if (took) hv = 1'b0;
        end
        // Close out: finish any held beat, then end the open frame.
        done = !hv;
        for (int k = 0; k < 20 && !done; k++) begin
            cyc(sel, 1'b1, ri, rl, 1'b1, took);
            if (took) done = 1'b1;
        end
        chk("drain_held_beat", 32'(done), 32'd1);
        if (cur_q.size() != 0) cyc(sel, 1'b1, 5'd0, 1'b1, 1'b1, took);
        cyc(sel, 1'b0, 5'd0, 1'b0, 1'b1, took);
        cyc(sel, 1'b0, 5'd0, 1'b0, 1'b1, took);
    endtask

    logic t;

    initial begin
        // Reset state on both widths, out_rdy low so in_rdy comes from the state.
        do_reset();
        if32.out_rdy = 1'b0;
        if20.out_rdy = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sample(s);
            chk("rst_out_vld", 32'(o_vld), 32'd0);
            chk("rst_out_vec", o_vec, 32'd0);
            chk("rst_out_cnt", 32'(o_cnt), 32'd0);
            chk("rst_in_rdy", 32'(o_rdy), 32'd1);
`ifdef IDX_TO_VEC_ACC_DUP_DETECT_EN
            chk("rst_out_dup", 32'(o_dup), 32'd0);
`endif
        end
        @(posedge clk);
        #1;

        // Three distinct indices.
        cyc(0, 1'b1, 5'd3, 1'b0, 1'b1, t);
        cyc(0, 1'b1, 5'd7, 1'b0, 1'b1, t);
        cyc(0, 1'b1, 5'd31, 1'b1, 1'b1, t);
        sample(0);
        chk("tp1_vld", 32'(o_vld), 32'd1);
        chk("tp1_vec", o_vec, 32'h8000_0088);
        chk("tp1_cnt", 32'(o_cnt), 32'd3);
        cyc(0, 1'b0, 5'd0, 1'b0, 1'b1, t);

        // Duplicate index.
        cyc(0, 1'b1, 5'd5, 1'b0, 1'b1, t);
        cyc(0, 1'b1, 5'd5, 1'b0, 1'b1, t);
        cyc(0, 1'b1, 5'd0, 1'b1, 1'b1, t);
        sample(0);
        chk("tp2_vec", o_vec, 32'h0000_0021);
        chk("tp2_cnt", 32'(o_cnt), 32'd2);
`ifdef IDX_TO_VEC_ACC_DUP_DETECT_EN
        chk("tp2_dup", 32'(o_dup), 32'd1);
`endif
        cyc(0, 1'b0, 5'd0, 1'b0, 1'b1, t);

        // Backpressure: frame held 4 cycles, pending beat 9 taken on release.
        cyc(0, 1'b1, 5'd1, 1'b1, 1'b0, t);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1'b1, 5'd9, 1'b0, 1'b0, t);
            chk("tp3_not_taken", 32'(t), 32'd0);
        end
        cyc(0, 1'b1, 5'd9, 1'b0, 1'b1, t);
        chk("tp3_taken", 32'(t), 32'd1);
        cyc(0, 1'b1, 5'd9, 1'b1, 1'b1, t);
        sample(0);
        chk("tp3_vec", o_vec, 32'h0000_0200);
        chk("tp3_cnt", 32'(o_cnt), 32'd1);
        cyc(0, 1'b0, 5'd0, 1'b0, 1'b1, t);

        // Back-to-back single-beat frames.
        cyc(0, 1'b1, 5'd0, 1'b1, 1'b1, t);
        cyc(0, 1'b1, 5'd1, 1'b1, 1'b1, t);
        cyc(0, 1'b1, 5'd2, 1'b1, 1'b1, t);
        sample(0);
        chk("tp4_vld", 32'(o_vld), 32'd1);
        chk("tp4_vec", o_vec, 32'h0000_0004);
        cyc(0, 1'b0, 5'd0, 1'b0, 1'b1, t);
        cyc(0, 1'b0, 5'd0, 1'b0, 1'b1, t);

        // Reset mid-frame discards the partial bitmap.
        cyc(0, 1'b1, 5'd2, 1'b0, 1'b1, t);
        cyc(0, 1'b1, 5'd4, 1'b0, 1'b1, t);
        do_reset();
        cyc(0, 1'b1, 5'd6, 1'b1, 1'b1, t);
        sample(0);
        chk("tp6_vec", o_vec, 32'h0000_0040);
        chk("tp6_cnt", 32'(o_cnt), 32'd1);
        cyc(0, 1'b0, 5'd0, 1'b0, 1'b1, t);

        run_random(0, 1500);

        // Non-power-of-two width with an out-of-range beat.
        cyc(1, 1'b1, 5'd25, 1'b0, 1'b1, t);
        cyc(1, 1'b1, 5'd19, 1'b1, 1'b1, t);
        sample(1);
        chk("tp5_vec", o_vec, 32'h0008_0000);
        chk("tp5_cnt", 32'(o_cnt), 32'd1);
`ifdef IDX_TO_VEC_ACC_DUP_DETECT_EN
        chk("tp5_dup", 32'(o_dup), 32'd1);
`endif
        cyc(1, 1'b0, 5'd0, 1'b0, 1'b1, t);

        // Frame of only out-of-range indices.
        cyc(1, 1'b1, 5'd30, 1'b0, 1'b1, t);
        cyc(1, 1'b1, 5'd20, 1'b1, 1'b1, t);
        sample(1);
        chk("oor_vld", 32'(o_vld), 32'd1);
        chk("oor_vec", o_vec, 32'd0);
        chk("oor_cnt", 32'(o_cnt), 32'd0);
        cyc(1, 1'b0, 5'd0, 1'b0, 1'b1, t);

        run_random(1, 1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_idx_to_vec_acc

`default_nettype wire
